down_count_chain: RTL and testbench

Cascadable synchronous down-counter: the count-down counterpart to the team's 74163-style up-counter chains. It is built as NIBBLES chained 4-bit down-counting cells and adds a small control FSM that reports expiry and can optionally auto-reload. It sits in the control path as a loop, delay or divider counter: software or the sequencer loads a value, and the block counts to zero, pulses DONE, then either stops or reloads.

---
 rtl/down_count_chain_pkg.sv | 10 +
 rtl/down_nibble.sv | 28 ++
 rtl/down_count_chain.sv | 92 +++++++++
 tb/tb_down_count_chain.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/down_count_chain_pkg.sv
// Shared types and constants for the cascadable down-counter chain.
package down_count_chain_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;
endpackage

// File: rtl/down_nibble.sv
// 4-bit down-counting cell: sync load, async clear, decrement on CEP & CET.
// Latency 1 edge; TC is combinational borrow-out for the next cell.
module down_nibble
  import down_count_chain_pkg::*;
(
  input  logic                CP,
  input  logic                _MR,
  input  logic                CEP,
  input  logic                CET,
  input  logic                _PE,
  input  logic [NIBBLE_W-1:0] D,
  output logic [NIBBLE_W-1:0] Q,
  output logic                TC
);

  always_ff @(posedge CP or negedge _MR) begin
    if (!_MR) begin
      Q <= '0;
    end else if (!_PE) begin
      Q <= D;
    end else if (CEP && CET) begin
      Q <= Q - 4'd1;
    end
  end

  assign TC = CET & (Q == '0);

endmodule

// File: rtl/down_count_chain.sv
// Chained down-counter with expiry FSM, one-cycle DONE pulse and optional reload.
// Load/decrement take effect on the sampling edge; TC is combinational, no backpressure.
module down_count_chain
  import down_count_chain_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                       CP,
  input  logic                       _MR,
  input  logic                       _PE,
  input  logic [NIBBLE_W*NIBBLES-1:0] D,
  input  logic                       CEP,
  input  logic                       CET,
  input  logic                       AUTO,
  output logic [NIBBLE_W*NIBBLES-1:0] Q,
  output logic                       TC,
  output logic                       DONE
);

  localparam int W = NIBBLE_W * NIBBLES;

  state_t             state;
  logic               en;
  logic               zero_hit;
  logic               q_is_one;
  logic               cell_pe_n;
  logic [W-1:0]       cell_d;
  logic [NIBBLES-1:0] tc_chain;

  assign en       = CEP & CET & (state == RUN);
  // Borrow out of the last cell means an enabled edge while the whole count is zero.
  assign zero_hit = tc_chain[NIBBLES-1];
  assign q_is_one = (Q == W'(1));

  // At zero the cells are loaded instead of decremented: D when reloading, 0 when
  // stopping, so the count never wraps to all-ones.
  assign cell_pe_n = _PE & ~zero_hit;
  assign cell_d    = (!_PE || AUTO) ? D : '0;

  for (genvar i = 0; i < NIBBLES; i++) begin : g_cell
    if (i == 0) begin : g_first
      down_nibble u_nibble (
        .CP  (CP),
        ._MR (_MR),
        .CEP (en),
        .CET (en),
        ._PE (cell_pe_n),
        .D   (cell_d[NIBBLE_W*i +: NIBBLE_W]),
        .Q   (Q[NIBBLE_W*i +: NIBBLE_W]),
        .TC  (tc_chain[i])
      );
    end else begin : g_next
      down_nibble u_nibble (
        .CP  (CP),
        ._MR (_MR),
        .CEP (en),
        .CET (tc_chain[i-1]),
        ._PE (cell_pe_n),
        .D   (cell_d[NIBBLE_W*i +: NIBBLE_W]),
        .Q   (Q[NIBBLE_W*i +: NIBBLE_W]),
        .TC  (tc_chain[i])
      );
    end
  end

  assign TC = CET & (Q == '0);

  always_ff @(posedge CP or negedge _MR) begin
    if (!_MR) begin
      state <= IDLE;
      DONE  <= 1'b0;
    end else if (!_PE) begin
      state <= RUN;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        RUN: begin
          if (en && q_is_one) begin
            DONE  <= 1'b1;
            state <= AUTO ? RUN : EXPIRED;
          end else if (zero_hit && !AUTO) begin
            state <= EXPIRED;
          end
        end
        EXPIRED: state <= EXPIRED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_count_chain.sv
// Bench for down_count_chain: directed vector table, reset corners, random vs model.
module tb_down_count_chain;

  logic       clk;
  logic       mr_n;
  logic       pe_n;
  logic [7:0] d;
  logic       cep;
  logic       cet;
  logic       auto_rl;
  logic [7:0] q;
  logic       tc;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: 0 idle, 1 running, 2 expired
  int m_q;
  int m_mode;
  bit m_done;

  down_count_chain #(.NIBBLES(2)) dut (
    .CP   (clk),
    ._MR  (mr_n),
    ._PE  (pe_n),
    .D    (d),
    .CEP  (cep),
    .CET  (cet),
    .AUTO (auto_rl),
    .Q    (q),
    .TC   (tc),
    .DONE (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pe_n;
    logic [7:0] d;
    logic       cep;
    logic       cet;
    logic       auto_rl;
    logic [7:0] exp_q;
    logic       exp_done;
    logic       exp_tc;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic [7:0] dv, input logic ce, input logic ct,
                     input logic au, input logic [7:0] eq, input logic ed, input logic et,
                     input string nm);
    vec_t v;
    v.pe_n = p; v.d = dv; v.cep = ce; v.cet = ct; v.auto_rl = au;
    v.exp_q = eq; v.exp_done = ed; v.exp_tc = et; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] eq, input logic ed, input logic et);
    checks++;
    if (q !== eq || done !== ed || tc !== et) begin
      errors++;
      $display("FAIL %s: got Q=%h DONE=%b TC=%b, want Q=%h DONE=%b TC=%b",
               nm, q, done, tc, eq, ed, et);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_mode = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (!pe_n) begin
      m_q = int'(d); m_mode = 1; m_done = 0;
    end else if (m_mode == 1 && cep && cet) begin
      if (m_q > 1) begin
        m_q = m_q - 1; m_done = 0;
      end else if (m_q == 1) begin
        m_q = 0; m_done = 1;
        if (!auto_rl) m_mode = 2;
      end else begin
        m_done = 0;
        if (auto_rl) m_q = int'(d);
        else m_mode = 2;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk(nm, 8'(m_q), m_done, cet && (m_q == 0));
  endtask

  initial begin
    mr_n = 1'b0; pe_n = 1'b1; d = 8'h00; cep = 1'b1; cet = 1'b1; auto_rl = 1'b0;
    model_reset();
    #12;
    chk("reset_state", 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("reset_held_edge", 8'h00, 1'b0, 1'b1);
    mr_n = 1'b1;
    step();
    chk("idle_ignores_en", 8'h00, 1'b0, 1'b1);

    // basic expiry
    add(0, 8'h02, 1, 1, 0, 8'h02, 0, 0, "exp_load");
    add(1, 8'h02, 1, 1, 0, 8'h01, 0, 0, "exp_dec1");
    add(1, 8'h02, 1, 1, 0, 8'h00, 1, 1, "exp_zero_done");
    add(1, 8'h02, 1, 1, 0, 8'h00, 0, 1, "exp_hold1");
    add(1, 8'h02, 1, 1, 0, 8'h00, 0, 1, "exp_hold2");
    add(1, 8'h02, 1, 1, 0, 8'h00, 0, 1, "exp_hold3");
    // nibble borrow and TC
    add(0, 8'h10, 1, 1, 0, 8'h10, 0, 0, "borrow_load");
    add(1, 8'h10, 1, 1, 0, 8'h0F, 0, 0, "borrow_dec");
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 1, "load0_tc");
    add(1, 8'h00, 1, 0, 0, 8'h00, 0, 0, "tc_cet_low");
    // auto-reload
    add(0, 8'h03, 1, 1, 1, 8'h03, 0, 0, "auto_load");
    add(1, 8'h03, 1, 1, 1, 8'h02, 0, 0, "auto_02");
    add(1, 8'h03, 1, 1, 1, 8'h01, 0, 0, "auto_01");
    add(1, 8'h03, 1, 1, 1, 8'h00, 1, 1, "auto_00_done");
    add(1, 8'h03, 1, 1, 1, 8'h03, 0, 0, "auto_reload");
    add(1, 8'h03, 1, 1, 1, 8'h02, 0, 0, "auto_02b");
    add(1, 8'h03, 1, 1, 1, 8'h01, 0, 0, "auto_01b");
    add(1, 8'h03, 1, 1, 1, 8'h00, 1, 1, "auto_00_done2");
    // enable gating
    add(0, 8'h05, 1, 1, 0, 8'h05, 0, 0, "gate_load");
    add(1, 8'h05, 0, 1, 0, 8'h05, 0, 0, "gate_cep0_a");
    add(1, 8'h05, 0, 1, 0, 8'h05, 0, 0, "gate_cep0_b");
    add(1, 8'h05, 1, 0, 0, 8'h05, 0, 0, "gate_cet0_a");
    add(1, 8'h05, 1, 0, 0, 8'h05, 0, 0, "gate_cet0_b");
    add(1, 8'h05, 1, 1, 0, 8'h04, 0, 0, "gate_resume");
    // load priority out of EXPIRED
    add(0, 8'h01, 1, 1, 0, 8'h01, 0, 0, "prio_load1");
    add(1, 8'h01, 1, 1, 0, 8'h00, 1, 1, "prio_expire");
    add(1, 8'h01, 1, 1, 0, 8'h00, 0, 1, "prio_expired");
    add(0, 8'h21, 1, 1, 0, 8'h21, 0, 0, "prio_load21");
    add(1, 8'h21, 1, 1, 0, 8'h20, 0, 0, "prio_dec20");

    for (int i = 0; i < vecs.size(); i++) begin
      pe_n = vecs[i].pe_n; d = vecs[i].d; cep = vecs[i].cep;
      cet = vecs[i].cet; auto_rl = vecs[i].auto_rl;
      step();
      chk(vecs[i].name, vecs[i].exp_q, vecs[i].exp_done, vecs[i].exp_tc);
    end

    // reset midway between edges during a run
    pe_n = 1'b0; d = 8'h07; cep = 1'b1; cet = 1'b1; auto_rl = 1'b0;
    step();
    chk("mid_rst_load", 8'h07, 1'b0, 1'b0);
    pe_n = 1'b1;
    #3;
    mr_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_async", 8'h00, 1'b0, 1'b1);
    #2;
    mr_n = 1'b1;
    step();
    chk("mid_rst_idle1", 8'h00, 1'b0, 1'b1);
    step();
    chk("mid_rst_idle2", 8'h00, 1'b0, 1'b1);

    // reset while DONE is high clears it without an edge
    pe_n = 1'b0; d = 8'h01;
    step();
    pe_n = 1'b1;
    step();
    chk("done_before_rst", 8'h00, 1'b1, 1'b1);
    #3;
    mr_n = 1'b0;
    #1;
    model_reset();
    chk("done_rst_async", 8'h00, 1'b0, 1'b1);
    #2;
    mr_n = 1'b1;

    // randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      pe_n    = ($urandom_range(0, 7) != 0);
      d       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      cep     = ($urandom_range(0, 3) != 0);
      cet     = ($urandom_range(0, 3) != 0);
      auto_rl = $urandom_range(0, 1) == 1;
      step();
      chk_model("random");
      if ($urandom_range(0, 79) == 0) begin
        #2;
        mr_n = 1'b0;
        #1;
        model_reset();
        chk_model("random_rst");
        #1;
        mr_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
